// File: rtl/column_window_filter_if.sv
// Line-buffer read port plus filtered-pixel stream for the column window filter.
// The filter drives raddr and samples col_in in the same cycle.
interface column_window_filter_if #(
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 12,
  parameter int unsigned SLICE = 3
);
  logic                  start;
  logic [AW-1:0]         raddr;
  logic [DW*SLICE-1:0]   col_in;
  logic [DW-1:0]         pix_out;
  logic [AW-1:0]         pix_col;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, col_in, pix_ready,
    output raddr, pix_out, pix_col, pix_valid, busy, done
  );

  modport slave (
    output start, col_in, pix_ready,
    input  raddr, pix_out, pix_col, pix_valid, busy, done
  );
endinterface

// File: rtl/column_window_filter.sv
// Sweeps one committed 3-row slice column by column and emits a 1-2-1 Gaussian
// blurred centre-row RGB444 pixel per column, replicating the left/right edges.
module column_window_filter #(
  parameter int unsigned HWIDTH = 640,
  parameter int unsigned AW     = 10
) (
  input logic                    clk,
  input logic                    rst,
  column_window_filter_if.master bus
);
  localparam int unsigned DW    = 12;
  localparam int unsigned SLICE = 3;
  localparam int unsigned CW    = DW * SLICE;
  localparam logic [AW-1:0] LAST_COL = AW'(HWIDTH - 1);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, FLUSH, DRAIN} state_t;

  state_t        state,     state_n;
  logic [AW-1:0] raddr,     raddr_n;
  logic [CW-1:0] win_l,     win_l_n;
  logic [CW-1:0] win_c,     win_c_n;
  logic [CW-1:0] win_r,     win_r_n;
  logic [DW-1:0] pix_out,   pix_out_n;
  logic [AW-1:0] pix_col,   pix_col_n;
  logic          pix_valid, pix_valid_n;
  logic          busy,      busy_n;
  logic          done,      done_n;
  logic          adv;

  // One 4-bit channel of one row, zero-extended to the 8-bit accumulator width.
  function automatic logic [7:0] px(input logic [CW-1:0] col, input int unsigned row,
                                    input int unsigned ch);
    return 8'(col[row*DW + ch*4 +: 4]);
  endfunction

  // Vertical 1-2-1 sum of one column for one channel (max 60).
  function automatic logic [7:0] col_w(input logic [CW-1:0] col, input int unsigned ch);
    return px(col, 0, ch) + (px(col, 1, ch) << 1) + px(col, 2, ch);
  endfunction

  // Horizontal 1-2-1 over the vertical sums; rounded divide by 16 (max sum 248).
  function automatic logic [DW-1:0] blur(input logic [CW-1:0] l, input logic [CW-1:0] c,
                                         input logic [CW-1:0] r);
    logic [DW-1:0] res;
    logic [7:0]    s;
    res = '0;
    for (int unsigned ch = 0; ch < 3; ch++) begin
      s = col_w(l, ch) + (col_w(c, ch) << 1) + col_w(r, ch) + 8'd8;
      res[ch*4 +: 4] = 4'(s >> 4);
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      raddr     <= '0;
      win_l     <= '0;
      win_c     <= '0;
      win_r     <= '0;
      pix_out   <= '0;
      pix_col   <= '0;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      raddr     <= raddr_n;
      win_l     <= win_l_n;
      win_c     <= win_c_n;
      win_r     <= win_r_n;
      pix_out   <= pix_out_n;
      pix_col   <= pix_col_n;
      pix_valid <= pix_valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    raddr_n     = raddr;
    win_l_n     = win_l;
    win_c_n     = win_c;
    win_r_n     = win_r;
    pix_out_n   = pix_out;
    pix_col_n   = pix_col;
    pix_valid_n = pix_valid;
    busy_n      = busy;
    done_n      = 1'b0;
    adv         = !pix_valid || bus.pix_ready;

    // busy stays high through the done cycle so a coincident start is ignored.
    if (done) busy_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start && !busy) begin
          state_n = PRIME;
          raddr_n = '0;
          busy_n  = 1'b1;
        end
      end
      PRIME: begin
        if (adv) begin
          win_l_n = bus.col_in;
          win_c_n = bus.col_in;
          win_r_n = bus.col_in;
          raddr_n = AW'(1);
          state_n = RUN;
        end
      end
      RUN: begin
        if (adv) begin
          win_l_n     = win_c;
          win_c_n     = win_r;
          win_r_n     = bus.col_in;
          pix_out_n   = blur(win_c, win_r, bus.col_in);
          pix_col_n   = raddr - AW'(1);
          pix_valid_n = 1'b1;
          if (raddr == LAST_COL) state_n = FLUSH;
          else                   raddr_n = raddr + AW'(1);
        end
      end
      FLUSH: begin
        if (adv) begin
          win_l_n     = win_c;
          win_c_n     = win_r;
          pix_out_n   = blur(win_c, win_r, win_r);
          pix_col_n   = LAST_COL;
          pix_valid_n = 1'b1;
          state_n     = DRAIN;
        end
      end
      DRAIN: begin
        if (pix_valid && bus.pix_ready) begin
          pix_valid_n = 1'b0;
          done_n      = 1'b1;
          raddr_n     = '0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.raddr     = raddr;
  assign bus.pix_out   = pix_out;
  assign bus.pix_col   = pix_col;
  assign bus.pix_valid = pix_valid;
  assign bus.busy      = busy;
  assign bus.done      = done;
endmodule

// File: tb/tb_column_window_filter.sv
// Randomized and directed bench for column_window_filter on an 8-column slice,
// checked against a direct 3x3 convolution model with clamped edge columns.
module tb_column_window_filter;
  localparam int W  = 8;
  localparam int AW = 3;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  logic [35:0] mem [W];

  column_window_filter_if #(.AW(AW), .DW(12), .SLICE(3)) bus ();

  column_window_filter #(.HWIDTH(W), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.col_in = mem[bus.raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-negedge traces of one run, plus accepted pixels.
  logic        tr_valid[$];
  logic        tr_ready[$];
  logic        tr_done[$];
  logic        tr_busy[$];
  logic [2:0]  tr_raddr[$];
  logic [11:0] tr_pix[$];
  logic [2:0]  tr_col[$];
  logic [11:0] got_pix[$];
  logic [2:0]  got_col[$];
  int          done_cnt;

  function automatic logic [11:0] model_pix(input int c);
    logic [11:0] res;
    int s, cc, w, nib;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      s = 0;
      for (int dr = 0; dr < 3; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          cc = c + dc;
          if (cc < 0) cc = 0;
          if (cc > W - 1) cc = W - 1;
          w = ((dr == 1) ? 2 : 1) * ((dc == 0) ? 2 : 1);
          nib = int'((mem[cc] >> (dr * 12 + ch * 4)) & 36'hF);
          s += w * nib;
        end
      end
      res[ch*4 +: 4] = 4'((s + 8) / 16);
    end
    return res;
  endfunction

  function automatic logic ready_pat(input int mode, input int idx);
    if (mode == 0) return 1'b1;
    return (idx % 3) == 0;
  endfunction

  // Pulse start and record traces until done plus six cycles, or time out.
  task automatic run_slice(input int mode, input bit extra_start, output bit timed_out);
    int done_idx;
    tr_valid.delete(); tr_ready.delete(); tr_done.delete(); tr_busy.delete();
    tr_raddr.delete(); tr_pix.delete(); tr_col.delete();
    got_pix.delete(); got_col.delete();
    done_cnt  = 0;
    done_idx  = -1;
    timed_out = 1'b0;
    bus.pix_ready = ready_pat(mode, 0);
    bus.start     = 1'b1;
    for (int idx = 1; idx <= 300; idx++) begin
      @(negedge clk);
      bus.start = 1'b0;
      tr_valid.push_back(bus.pix_valid);
      tr_done.push_back(bus.done);
      tr_busy.push_back(bus.busy);
      tr_raddr.push_back(bus.raddr);
      tr_pix.push_back(bus.pix_out);
      tr_col.push_back(bus.pix_col);
      if (bus.done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = idx;
      end
      if (extra_start && (idx == 5 || bus.done)) bus.start = 1'b1;
      bus.pix_ready = ready_pat(mode, idx);
      tr_ready.push_back(bus.pix_ready);
      if (bus.pix_valid && bus.pix_ready) begin
        got_pix.push_back(bus.pix_out);
        got_col.push_back(bus.pix_col);
      end
      if (done_idx >= 0 && idx >= done_idx + 6) break;
    end
    if (done_idx < 0) timed_out = 1'b1;
    bus.start     = 1'b0;
    bus.pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.pix_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.raddr !== 3'd0) begin tests_failed++; $display("FAIL reset_raddr got=%0d exp=0", bus.raddr); end
    tests_run++; if (bus.pix_out !== 12'h0) begin tests_failed++; $display("FAIL reset_pix_out got=%h exp=000", bus.pix_out); end
    tests_run++; if (bus.pix_col !== 3'd0) begin tests_failed++; $display("FAIL reset_pix_col got=%0d exp=0", bus.pix_col); end
    tests_run++; if (bus.pix_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", bus.pix_valid); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", bus.done); end
  endtask

  task automatic test_all_ones();
    bit to;
    int first, nvalid, d;
    for (int c = 0; c < W; c++) mem[c] = 36'hFFF_FFF_FFF;
    run_slice(0, 1'b0, to);
    tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL ones_timeout got=%b exp=0", to); end
    first = -1; nvalid = 0; d = -1;
    foreach (tr_valid[i]) begin
      if (tr_valid[i] && first < 0) first = i;
      if (tr_valid[i]) nvalid++;
      if (tr_done[i] && d < 0) d = i;
    end
    tests_run++; if (first !== 2) begin tests_failed++; $display("FAIL ones_first_valid got=%0d exp=2", first); end
    tests_run++; if (nvalid !== W) begin tests_failed++; $display("FAIL ones_valid_count got=%0d exp=%0d", nvalid, W); end
    tests_run++; if (d !== first + W) begin tests_failed++; $display("FAIL ones_done_pos got=%0d exp=%0d", d, first + W); end
    tests_run++; if (tr_busy[0] !== 1'b1) begin tests_failed++; $display("FAIL ones_busy_start got=%b exp=1", tr_busy[0]); end
    if (d >= 0 && d + 1 < tr_busy.size()) begin
      tests_run++; if (tr_busy[d+1] !== 1'b0) begin tests_failed++; $display("FAIL ones_busy_after_done got=%b exp=0", tr_busy[d+1]); end
    end
    tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL ones_done_count got=%0d exp=1", done_cnt); end
    tests_run++; if (got_pix.size() !== W) begin tests_failed++; $display("FAIL ones_npix got=%0d exp=%0d", got_pix.size(), W); end
    foreach (got_pix[i]) begin
      tests_run++; if (got_pix[i] !== 12'hFFF) begin tests_failed++; $display("FAIL ones_pix[%0d] got=%h exp=fff", i, got_pix[i]); end
      tests_run++; if (got_col[i] !== 3'(i)) begin tests_failed++; $display("FAIL ones_col[%0d] got=%0d exp=%0d", i, got_col[i], i); end
    end
  endtask

  task automatic test_impulse_edge();
    bit to;
    logic [3:0] r_exp [W];
    for (int c = 0; c < W; c++) begin mem[c] = '0; r_exp[c] = 4'd0; end
    mem[3] = 36'h000_F00_000;
    r_exp[2] = 4'd2; r_exp[3] = 4'd4; r_exp[4] = 4'd2;
    run_slice(0, 1'b0, to);
    tests_run++; if (got_pix.size() !== W) begin tests_failed++; $display("FAIL impulse_npix got=%0d exp=%0d", got_pix.size(), W); end
    foreach (got_pix[i]) begin
      tests_run++; if (got_pix[i] !== {r_exp[i], 8'h00}) begin tests_failed++; $display("FAIL impulse_pix[%0d] got=%h exp=%h", i, got_pix[i], {r_exp[i], 8'h00}); end
    end
    for (int c = 0; c < W; c++) mem[c] = '0;
    mem[0] = 36'h0F0_0F0_0F0;
    run_slice(0, 1'b0, to);
    tests_run++; if (got_pix.size() !== W) begin tests_failed++; $display("FAIL edge_npix got=%0d exp=%0d", got_pix.size(), W); end
    if (got_pix.size() >= 2) begin
      tests_run++; if (got_pix[0] !== 12'h0B0) begin tests_failed++; $display("FAIL edge_col0 got=%h exp=0b0", got_pix[0]); end
      tests_run++; if (got_pix[1] !== 12'h040) begin tests_failed++; $display("FAIL edge_col1 got=%h exp=040", got_pix[1]); end
    end
  endtask

  task automatic test_random();
    bit to;
    for (int it = 0; it < 4; it++) begin
      for (int c = 0; c < W; c++) mem[c] = {4'($urandom), $urandom};
      mem[W-1][11:0] = 12'hFFF;
      run_slice(it % 2, 1'b0, to);
      tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL rand%0d_timeout got=%b exp=0", it, to); end
      tests_run++; if (got_pix.size() !== W) begin tests_failed++; $display("FAIL rand%0d_npix got=%0d exp=%0d", it, got_pix.size(), W); end
      foreach (got_pix[i]) begin
        tests_run++; if (got_pix[i] !== model_pix(i)) begin tests_failed++; $display("FAIL rand%0d_pix[%0d] got=%h exp=%h", it, i, got_pix[i], model_pix(i)); end
        tests_run++; if (got_col[i] !== 3'(i)) begin tests_failed++; $display("FAIL rand%0d_col[%0d] got=%0d exp=%0d", it, i, got_col[i], i); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int last_hs, d;
    for (int c = 0; c < W; c++) mem[c] = {4'($urandom), $urandom};
    run_slice(1, 1'b0, to);
    tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL bp_timeout got=%b exp=0", to); end
    last_hs = -1; d = -1;
    for (int i = 0; i < tr_valid.size(); i++) begin
      if (tr_valid[i] && tr_ready[i]) last_hs = i;
      if (tr_done[i] && d < 0) d = i;
      if (i + 1 < tr_valid.size() && tr_valid[i] && !tr_ready[i]) begin
        tests_run++; if (tr_valid[i+1] !== 1'b1) begin tests_failed++; $display("FAIL bp_valid_hold[%0d] got=%b exp=1", i, tr_valid[i+1]); end
        tests_run++; if (tr_pix[i+1] !== tr_pix[i]) begin tests_failed++; $display("FAIL bp_pix_hold[%0d] got=%h exp=%h", i, tr_pix[i+1], tr_pix[i]); end
        tests_run++; if (tr_col[i+1] !== tr_col[i]) begin tests_failed++; $display("FAIL bp_col_hold[%0d] got=%0d exp=%0d", i, tr_col[i+1], tr_col[i]); end
        tests_run++; if (tr_raddr[i+1] !== tr_raddr[i]) begin tests_failed++; $display("FAIL bp_raddr_hold[%0d] got=%0d exp=%0d", i, tr_raddr[i+1], tr_raddr[i]); end
      end
    end
    tests_run++; if (d !== last_hs + 1) begin tests_failed++; $display("FAIL bp_done_pos got=%0d exp=%0d", d, last_hs + 1); end
    tests_run++; if (got_pix.size() !== W) begin tests_failed++; $display("FAIL bp_npix got=%0d exp=%0d", got_pix.size(), W); end
    foreach (got_pix[i]) begin
      tests_run++; if (got_col[i] !== 3'(i)) begin tests_failed++; $display("FAIL bp_col[%0d] got=%0d exp=%0d", i, got_col[i], i); end
      tests_run++; if (got_pix[i] !== model_pix(i)) begin tests_failed++; $display("FAIL bp_pix[%0d] got=%h exp=%h", i, got_pix[i], model_pix(i)); end
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    int nvalid, d;
    for (int c = 0; c < W; c++) mem[c] = {4'($urandom), $urandom};
    run_slice(0, 1'b1, to);
    nvalid = 0; d = -1;
    foreach (tr_valid[i]) begin
      if (tr_valid[i]) nvalid++;
      if (tr_done[i] && d < 0) d = i;
    end
    tests_run++; if (nvalid !== W) begin tests_failed++; $display("FAIL ign_valid_count got=%0d exp=%0d", nvalid, W); end
    tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL ign_done_count got=%0d exp=1", done_cnt); end
    tests_run++; if (tr_busy[tr_busy.size()-1] !== 1'b0) begin tests_failed++; $display("FAIL ign_busy_end got=%b exp=0", tr_busy[tr_busy.size()-1]); end
    tests_run++; if (got_col.size() !== W) begin tests_failed++; $display("FAIL ign_npix got=%0d exp=%0d", got_col.size(), W); end
    run_slice(0, 1'b0, to);
    tests_run++; if (got_pix.size() !== W) begin tests_failed++; $display("FAIL ign_rerun_npix got=%0d exp=%0d", got_pix.size(), W); end
    foreach (got_pix[i]) begin
      tests_run++; if (got_pix[i] !== model_pix(i)) begin tests_failed++; $display("FAIL ign_rerun_pix[%0d] got=%h exp=%h", i, got_pix[i], model_pix(i)); end
    end
  endtask

  task automatic test_reset_mid();
    bit to, hit;
    int dones;
    for (int c = 0; c < W; c++) mem[c] = {4'($urandom), $urandom};
    hit = 1'b0; dones = 0;
    bus.pix_ready = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (bus.pix_valid && bus.pix_col == 3'd4) hit = 1'b1;
    end
    tests_run++; if (hit !== 1'b1) begin tests_failed++; $display("FAIL rstmid_reach_col4 got=%b exp=1", hit); end
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (bus.pix_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_valid got=%b exp=0", bus.pix_valid); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    tests_run++; if (bus.raddr !== 3'd0) begin tests_failed++; $display("FAIL rstmid_raddr got=%0d exp=0", bus.raddr); end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done || bus.pix_valid) dones++;
    end
    tests_run++; if (dones !== 0) begin tests_failed++; $display("FAIL rstmid_no_done got=%0d exp=0", dones); end
    run_slice(0, 1'b0, to);
    tests_run++; if (got_col.size() !== W) begin tests_failed++; $display("FAIL rstmid_rerun_npix got=%0d exp=%0d", got_col.size(), W); end
    foreach (got_col[i]) begin
      tests_run++; if (got_col[i] !== 3'(i)) begin tests_failed++; $display("FAIL rstmid_rerun_col[%0d] got=%0d exp=%0d", i, got_col[i], i); end
      tests_run++; if (got_pix[i] !== model_pix(i)) begin tests_failed++; $display("FAIL rstmid_rerun_pix[%0d] got=%h exp=%h", i, got_pix[i], model_pix(i)); end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    for (int c = 0; c < W; c++) mem[c] = '0;
    test_reset();
    test_all_ones();
    test_impulse_edge();
    test_random();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
